// File: rtl/ram_pkg.sv
// Shared types and default geometry for the banked RAM.
// The default values mirror the original 16M x 16 part (8 banks of 2M words).
package ram_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int ADDR_W_DEF    = 24;
    localparam int BANK_BITS_DEF = 3;
    localparam int LOC_W         = ADDR_W_DEF - BANK_BITS_DEF;
    localparam int NBANK         = 2 ** BANK_BITS_DEF;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } ram_state_t;

    function automatic int locWidth(input int addrW, input int bankBits);
        return addrW - bankBits;
    endfunction

endpackage

// File: rtl/ram_bank.sv
// One RAM bank: a single write port and two synchronous read ports.
// Read data registers update only on their enable, so they hold otherwise.
module ram_bank #(
    parameter int DATA_W = 16,
    parameter int LOC_W  = 21
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [LOC_W-1:0]  wAddr_i,
    input  logic [DATA_W-1:0] wData_i,
    input  logic              reA_i,
    input  logic [LOC_W-1:0]  rAddrA_i,
    output logic [DATA_W-1:0] rDataA_o,
    input  logic              reB_i,
    input  logic [LOC_W-1:0]  rAddrB_i,
    output logic [DATA_W-1:0] rDataB_o
);

    logic [DATA_W-1:0] mem_q [2**LOC_W];

    // Non-blocking update of mem_q makes same-edge reads return the old word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wAddr_i] <= wData_i;
        end
        if (reA_i) begin
            rDataA_o <= mem_q[rAddrA_i];
        end
        if (reB_i) begin
            rDataB_o <= mem_q[rAddrB_i];
        end
    end

endmodule

// File: rtl/ram_banked.sv
// Multi-bank RAM: one write port, two registered read ports, and a clear sequencer after reset.
// Define RAMB_BYPASS_EN to forward same-cycle write data to a matching read (write-first).
module ram_banked
    import ram_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int BANK_BITS = BANK_BITS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] d_in,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] d_out_a,
    output logic              valid_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] d_out_b,
    output logic              valid_b,
    output logic              busy
);

    localparam int LocW  = locWidth(ADDR_W, BANK_BITS);
    localparam int NBank = 2 ** BANK_BITS;
    localparam logic [LocW-1:0] LastIdx = '1;

    ram_state_t        state_q;
    logic [LocW-1:0]   clrIdx_q;
    logic              busy_q;

    logic              wrEff, rdEffA, rdEffB;
    logic [NBank-1:0]  bankWe, bankReA, bankReB;
    logic [LocW-1:0]   bankWAddr;
    logic [DATA_W-1:0] bankWData;
    logic [DATA_W-1:0] bankDataA [NBank];
    logic [DATA_W-1:0] bankDataB [NBank];

    logic [BANK_BITS-1:0] selA_q, selB_q;
    logic                 validA_q, validB_q;
    logic [DATA_W-1:0]    holdA_q, holdB_q;
    logic [DATA_W-1:0]    curA, curB;

    assign wrEff  = wr && (state_q == IDLE);
    assign rdEffA = rd_en_a && (state_q == IDLE);
    assign rdEffB = rd_en_b && (state_q == IDLE);

    // While clearing, every bank is written with zero at the same local index.
    always_comb begin
        bankWe    = '0;
        bankReA   = '0;
        bankReB   = '0;
        bankWAddr = wr_addr[LocW-1:0];
        bankWData = d_in;
        if (state_q == CLEAR) begin
            bankWe    = '1;
            bankWAddr = clrIdx_q;
            bankWData = '0;
        end else if (wrEff) begin
            bankWe[wr_addr[ADDR_W-1:LocW]] = 1'b1;
        end
        if (rdEffA) bankReA[rd_addr_a[ADDR_W-1:LocW]] = 1'b1;
        if (rdEffB) bankReB[rd_addr_b[ADDR_W-1:LocW]] = 1'b1;
    end

    for (genvar b = 0; b < NBank; b++) begin : g_bank
        ram_bank #(
            .DATA_W (DATA_W),
            .LOC_W  (LocW)
        ) u_bank (
            .clk      (clk),
            .we_i     (bankWe[b]),
            .wAddr_i  (bankWAddr),
            .wData_i  (bankWData),
            .reA_i    (bankReA[b]),
            .rAddrA_i (rd_addr_a[LocW-1:0]),
            .rDataA_o (bankDataA[b]),
            .reB_i    (bankReB[b]),
            .rAddrB_i (rd_addr_b[LocW-1:0]),
            .rDataB_o (bankDataB[b])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= CLEAR;
            clrIdx_q <= '0;
            busy_q   <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    clrIdx_q <= clrIdx_q + 1'b1;
                    if (clrIdx_q == LastIdx) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The hold registers keep the last delivered word visible once valid drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            validA_q <= 1'b0;
            validB_q <= 1'b0;
            selA_q   <= '0;
            selB_q   <= '0;
            holdA_q  <= '0;
            holdB_q  <= '0;
        end else begin
            validA_q <= rdEffA;
            validB_q <= rdEffB;
            if (rdEffA) selA_q <= rd_addr_a[ADDR_W-1:LocW];
            if (rdEffB) selB_q <= rd_addr_b[ADDR_W-1:LocW];
            if (validA_q) holdA_q <= curA;
            if (validB_q) holdB_q <= curB;
        end
    end

`ifdef RAMB_BYPASS_EN
    logic              fwdA_q, fwdB_q;
    logic [DATA_W-1:0] fwdData_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fwdA_q    <= 1'b0;
            fwdB_q    <= 1'b0;
            fwdData_q <= '0;
        end else begin
            fwdA_q    <= rdEffA && wrEff && (rd_addr_a == wr_addr);
            fwdB_q    <= rdEffB && wrEff && (rd_addr_b == wr_addr);
            fwdData_q <= d_in;
        end
    end

    assign curA = fwdA_q ? fwdData_q : bankDataA[selA_q];
    assign curB = fwdB_q ? fwdData_q : bankDataB[selB_q];
`else
    assign curA = bankDataA[selA_q];
    assign curB = bankDataB[selB_q];
`endif

    assign d_out_a = validA_q ? curA : holdA_q;
    assign d_out_b = validB_q ? curB : holdB_q;
    assign valid_a = validA_q;
    assign valid_b = validB_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_ram_banked.sv
// Self-checking bench for ram_banked (4 banks x 64 words): directed scenarios plus random traffic
// compared every cycle against a flat-array reference model. Honours RAMB_BYPASS_EN.
module tb_ram_banked;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 8;
    localparam int BANK_BITS = 2;
    localparam int NLOC      = 64;
    localparam int NBANK     = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              wr = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] d_in = '0;
    logic              rd_en_a = 1'b0;
    logic [ADDR_W-1:0] rd_addr_a = '0;
    logic [DATA_W-1:0] d_out_a;
    logic              valid_a;
    logic              rd_en_b = 1'b0;
    logic [ADDR_W-1:0] rd_addr_b = '0;
    logic [DATA_W-1:0] d_out_b;
    logic              valid_b;
    logic              busy;

    int checks = 0;
    int failures = 0;

    // Reference model: a flat word array plus the expected read-port state.
    logic [DATA_W-1:0] model [2**ADDR_W];
    int                edgesSince = 0;
    logic              expValidA = 1'b0, expValidB = 1'b0;
    logic [DATA_W-1:0] expDataA = '0, expDataB = '0;

    always #5 clk = ~clk;

    ram_banked #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BANK_BITS (BANK_BITS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr),
        .wr_addr   (wr_addr),
        .d_in      (d_in),
        .rd_en_a   (rd_en_a),
        .rd_addr_a (rd_addr_a),
        .d_out_a   (d_out_a),
        .valid_a   (valid_a),
        .rd_en_b   (rd_en_b),
        .rd_addr_b (rd_addr_b),
        .d_out_b   (d_out_b),
        .valid_b   (valid_b),
        .busy      (busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic [7:0] wa, input logic [15:0] d,
                                 input logic ra, input logic [7:0] aa,
                                 input logic rb, input logic [7:0] ab);
        @(negedge clk);
        wr = w; wr_addr = wa; d_in = d;
        rd_en_a = ra; rd_addr_a = aa;
        rd_en_b = rb; rd_addr_b = ab;
    endtask

    function automatic logic [DATA_W-1:0] readModel(input logic [ADDR_W-1:0] addr);
`ifdef RAMB_BYPASS_EN
        if (wr && (addr == wr_addr)) return d_in;
`endif
        return model[addr];
    endfunction

    always @(negedge reset) begin
        edgesSince = 0;
        expValidA  = 1'b0;
        expValidB  = 1'b0;
        expDataA   = '0;
        expDataB   = '0;
    end

    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) model[i] = '0;
        forever begin
            @(posedge clk);
            if (reset) begin
                if (edgesSince < NLOC) begin
                    for (int b = 0; b < NBANK; b++) model[b*NLOC + edgesSince] = '0;
                    expValidA = 1'b0;
                    expValidB = 1'b0;
                    edgesSince++;
                end else begin
                    expValidA = rd_en_a;
                    expValidB = rd_en_b;
                    if (rd_en_a) expDataA = readModel(rd_addr_a);
                    if (rd_en_b) expDataB = readModel(rd_addr_b);
                    if (wr) model[wr_addr] = d_in;
                end
                #1;
                if (reset) begin
                    checkOutput("busy", 32'(busy), 32'(edgesSince < NLOC));
                    checkOutput("valid_a", 32'(valid_a), 32'(expValidA));
                    checkOutput("valid_b", 32'(valid_b), 32'(expValidB));
                    checkOutput("d_out_a", 32'(d_out_a), 32'(expDataA));
                    checkOutput("d_out_b", 32'(d_out_b), 32'(expDataB));
                end
            end
        end
    end

    int cnt;
    logic [15:0] exp4;

    initial begin
        // Reset, then a write attempted on clear cycle 10 must be ignored.
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd1);
        checkOutput("reset_valid_a", 32'(valid_a), 32'd0);
        checkOutput("reset_dout_a", 32'(d_out_a), 32'd0);
        reset = 1'b1;
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
            if (cnt == 10) begin
                wr = 1'b1; wr_addr = 8'h20; d_in = 16'h1234;
            end else if (cnt == 11) begin
                wr = 1'b0;
            end
        end
        checkOutput("clear_len", 32'(cnt), 32'd64);

        applyStimulus(0, 8'h00, 16'h0, 1, 8'h00, 1, 8'h7F);
        applyStimulus(0, 8'h00, 16'h0, 1, 8'hFF, 1, 8'h20);
        checkOutput("rd00", 32'(d_out_a), 32'h0000);
        checkOutput("rd7F", 32'(d_out_b), 32'h0000);
        applyStimulus(0, 8'h00, 16'h0, 0, 8'h00, 0, 8'h00);
        checkOutput("rdFF", 32'(d_out_a), 32'h0000);
        checkOutput("rd20_after_clear_write", 32'(d_out_b), 32'h0000);

        // Simple write then read.
        applyStimulus(1, 8'h41, 16'hBEEF, 0, 8'h00, 0, 8'h00);
        applyStimulus(0, 8'h00, 16'h0, 1, 8'h41, 0, 8'h00);
        applyStimulus(0, 8'h00, 16'h0, 0, 8'h00, 0, 8'h00);
        checkOutput("rd41", 32'(d_out_a), 32'hBEEF);
        checkOutput("rd41_valid", 32'(valid_a), 32'd1);
        applyStimulus(0, 8'h00, 16'h0, 0, 8'h00, 0, 8'h00);
        checkOutput("rd41_valid_drop", 32'(valid_a), 32'd0);
        checkOutput("rd41_hold", 32'(d_out_a), 32'hBEEF);

        // Same local index in two banks, read on both ports together.
        applyStimulus(1, 8'h05, 16'h1111, 0, 8'h00, 0, 8'h00);
        applyStimulus(1, 8'h45, 16'h2222, 0, 8'h00, 0, 8'h00);
        applyStimulus(0, 8'h00, 16'h0, 1, 8'h05, 1, 8'h45);
        applyStimulus(0, 8'h00, 16'h0, 0, 8'h00, 0, 8'h00);
        checkOutput("rd05_a", 32'(d_out_a), 32'h1111);
        checkOutput("rd45_b", 32'(d_out_b), 32'h2222);

        // Same-cycle write and read of one address.
`ifdef RAMB_BYPASS_EN
        exp4 = 16'h0BBB;
`else
        exp4 = 16'h0AAA;
`endif
        applyStimulus(1, 8'h10, 16'h0AAA, 0, 8'h00, 0, 8'h00);
        applyStimulus(1, 8'h10, 16'h0BBB, 1, 8'h10, 0, 8'h00);
        applyStimulus(0, 8'h00, 16'h0, 1, 8'h10, 0, 8'h00);
        checkOutput("rw_collide", 32'(d_out_a), 32'(exp4));
        applyStimulus(0, 8'h00, 16'h0, 0, 8'h00, 0, 8'h00);
        checkOutput("rw_after", 32'(d_out_a), 32'h0BBB);

        // Random traffic over a small address window so reads hit earlier writes.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            wr        = 1'($urandom_range(0, 1));
            wr_addr   = {2'($urandom_range(0, 3)), 6'($urandom_range(0, 7))};
            d_in      = 16'($urandom);
            rd_en_a   = 1'($urandom_range(0, 1));
            rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr
                        : {2'($urandom_range(0, 3)), 6'($urandom_range(0, 7))};
            rd_en_b   = 1'($urandom_range(0, 1));
            rd_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr
                        : {2'($urandom_range(0, 3)), 6'($urandom_range(0, 7))};
        end

        // Reset in the middle of a valid read cycle.
        applyStimulus(1, 8'h33, 16'h5A5A, 0, 8'h00, 0, 8'h00);
        applyStimulus(0, 8'h00, 16'h0, 1, 8'h33, 0, 8'h00);
        @(posedge clk); #1;
        checkOutput("pre_reset_valid", 32'(valid_a), 32'd1);
        checkOutput("pre_reset_data", 32'(d_out_a), 32'h5A5A);
        #2;
        rd_en_a = 1'b0;
        reset = 1'b0;
        #1;
        checkOutput("async_valid_a", 32'(valid_a), 32'd0);
        checkOutput("async_dout_a", 32'(d_out_a), 32'd0);
        checkOutput("async_busy", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        checkOutput("clear_len_restart", 32'(cnt), 32'd64);
        applyStimulus(0, 8'h00, 16'h0, 1, 8'h33, 1, 8'h41);
        applyStimulus(0, 8'h00, 16'h0, 0, 8'h00, 0, 8'h00);
        checkOutput("rd33_cleared", 32'(d_out_a), 32'h0000);
        checkOutput("rd41_cleared", 32'(d_out_b), 32'h0000);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
